// File: rtl/direction_queue_ctrl.sv
// Turns raw one-hot button presses into a paced turn queue, applying at most one turn per game tick.
// Define DIR_REVERSE_BLOCK_EN to discard presses opposite to the reference direction.
module direction_queue_ctrl #(
  parameter int         QUEUE_DEPTH = 2,
  parameter logic [3:0] INIT_DIR    = 4'b0010
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   btn_dir,
  input  logic                         game_tick,
  input  logic                         game_active,
  output logic [3:0]                   cur_dir,
  output logic                         dir_changed,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         queue_full,
  output logic                         press_dropped
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic          flush, load_init;
  logic [3:0]    btn_prev;
  logic [3:0]    q_mem [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [3:0]    ref_dir;
  logic          press, accept, full, empty, push, pop, drop, run_ok;

  function automatic logic is_onehot(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
  endfunction

`ifdef DIR_REVERSE_BLOCK_EN
  // left<->right, up<->down
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    load_init = 1'b0;
    case (state)
      IDLE: begin
        flush = 1'b1;
        if (game_active) begin
          state_nxt = RUN;
          load_init = 1'b1;
        end
      end
      RUN: begin
        if (!game_active) begin
          state_nxt = IDLE;
          flush     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run_ok  = (state == RUN) && game_active;
  assign empty   = (count == '0);
  assign full    = (count == CW'(QUEUE_DEPTH));
  // New turns are checked against the last queued turn, not the one currently applied
  assign ref_dir = empty ? cur_dir : q_mem[wr_ptr - PW'(1)];
  assign press   = is_onehot(btn_dir) && (btn_dir != btn_prev);

  always_comb begin
    accept = run_ok && press && (btn_dir != ref_dir);
`ifdef DIR_REVERSE_BLOCK_EN
    if (btn_dir == opposite(ref_dir)) accept = 1'b0;
`endif
  end

  assign pop  = run_ok && game_tick && !empty;
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev      <= 4'b0000;
      cur_dir       <= INIT_DIR;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      dir_changed   <= 1'b0;
      press_dropped <= 1'b0;
    end else begin
      btn_prev      <= btn_dir;
      dir_changed   <= pop;
      press_dropped <= drop;
      if (load_init) cur_dir <= INIT_DIR;
      else if (pop)  cur_dir <= q_mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage carries no reset; entries are only read while count covers them
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= btn_dir;
  end

  assign queue_count = count;
  assign queue_full  = full;

endmodule

// File: tb/tb_direction_queue_ctrl.sv
// Directed bench for direction_queue_ctrl: presses, ticks, filtering, overflow, flush and async reset.
module tb_direction_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_dir;
  logic       game_tick;
  logic       game_active;
  logic [3:0] cur_dir;
  logic       dir_changed;
  logic [1:0] queue_count;
  logic       queue_full;
  logic       press_dropped;

  int checks   = 0;
  int failures = 0;

  direction_queue_ctrl #(.QUEUE_DEPTH(2), .INIT_DIR(4'b0010)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_dir       (btn_dir),
    .game_tick     (game_tick),
    .game_active   (game_active),
    .cur_dir       (cur_dir),
    .dir_changed   (dir_changed),
    .queue_count   (queue_count),
    .queue_full    (queue_full),
    .press_dropped (press_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    game_active = 1'b0;
    clk_step();
    game_active = 1'b1;
    clk_step();
  endtask

  initial begin
    rst_n = 1'b0; btn_dir = 4'b0000; game_tick = 1'b0; game_active = 1'b0;
    #12;
    check("rst_cur_dir", cur_dir, 4'b0010);
    check("rst_count", queue_count, 0);
    check("rst_full", queue_full, 0);
    check("rst_changed", dir_changed, 0);
    check("rst_dropped", press_dropped, 0);

    // Start game, three idle ticks
    @(posedge clk); #1;
    rst_n = 1'b1; game_active = 1'b1;
    clk_step();
    check("start_cur_dir", cur_dir, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      game_tick = 1'b1; clk_step();
      check("idle_tick_cur_dir", cur_dir, 4'b0010);
      check("idle_tick_changed", dir_changed, 0);
      game_tick = 1'b0; clk_step();
      check("idle_tick_count", queue_count, 0);
    end

    // Single press up, then tick
    btn_dir = 4'b0100; clk_step();
    check("up_count", queue_count, 1);
    btn_dir = 4'b0000; clk_step();
    check("up_cur_before_tick", cur_dir, 4'b0010);
    game_tick = 1'b1; clk_step();
    check("up_cur_after_tick", cur_dir, 4'b0100);
    check("up_changed", dir_changed, 1);
    check("up_count_after", queue_count, 0);
    game_tick = 1'b0; clk_step();
    check("up_changed_one_cycle", dir_changed, 0);

    restart();
    check("restart_cur_dir", cur_dir, 4'b0010);

    // Double tap up then left, two ticks
    btn_dir = 4'b0100; clk_step();
    btn_dir = 4'b0000; clk_step();
    btn_dir = 4'b0001; clk_step();
    check("dbl_count", queue_count, 2);
    check("dbl_full", queue_full, 1);
    btn_dir = 4'b0000; clk_step();
    game_tick = 1'b1; clk_step();
    check("dbl_tick1_cur", cur_dir, 4'b0100);
    check("dbl_tick1_count", queue_count, 1);
    check("dbl_tick1_full", queue_full, 0);
    game_tick = 1'b0; clk_step();
    game_tick = 1'b1; clk_step();
    check("dbl_tick2_cur", cur_dir, 4'b0001);
    check("dbl_tick2_count", queue_count, 0);
    game_tick = 1'b0; clk_step();

    // Press and tick together on an empty queue: queued, not applied
    btn_dir = 4'b0100; game_tick = 1'b1; clk_step();
    check("nobypass_count", queue_count, 1);
    check("nobypass_cur", cur_dir, 4'b0001);
    check("nobypass_changed", dir_changed, 0);
    btn_dir = 4'b0000; game_tick = 1'b0; clk_step();
    game_tick = 1'b1; clk_step();
    check("nobypass_applied", cur_dir, 4'b0100);
    check("nobypass_applied_chg", dir_changed, 1);
    game_tick = 1'b0; clk_step();

    restart();
    check("restart2_cur_dir", cur_dir, 4'b0010);

    // Overflow: up, left, down with no tick
    btn_dir = 4'b0100; clk_step();
    btn_dir = 4'b0000; clk_step();
    btn_dir = 4'b0001; clk_step();
    check("ovf_full", queue_full, 1);
    btn_dir = 4'b0000; clk_step();
    btn_dir = 4'b1000; clk_step();
    check("ovf_dropped", press_dropped, 1);
    check("ovf_count", queue_count, 2);
    btn_dir = 4'b0000; clk_step();
    check("ovf_dropped_one_cycle", press_dropped, 0);
    // Full queue with simultaneous push and pop: push succeeds
    btn_dir = 4'b1000; game_tick = 1'b1; clk_step();
    check("fullpp_cur", cur_dir, 4'b0100);
    check("fullpp_changed", dir_changed, 1);
    check("fullpp_count", queue_count, 2);
    check("fullpp_dropped", press_dropped, 0);
    btn_dir = 4'b0000; game_tick = 1'b0; clk_step();

    // Drop game_active with a full queue
    game_active = 1'b0; clk_step();
    check("flush_count", queue_count, 0);
    check("flush_full", queue_full, 0);
    check("flush_cur_held", cur_dir, 4'b0100);
    check("flush_changed", dir_changed, 0);
    game_active = 1'b1; clk_step();
    check("reactivate_cur", cur_dir, 4'b0010);

    // Multi-hot inputs never push or drop
    btn_dir = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      check("multi4_count", queue_count, 0);
      check("multi4_dropped", press_dropped, 0);
    end
    btn_dir = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      check("multi2_count", queue_count, 0);
      check("multi2_dropped", press_dropped, 0);
    end
    btn_dir = 4'b0000; clk_step();

    // Same direction discarded
    btn_dir = 4'b0010; clk_step();
    check("same_dir_count", queue_count, 0);
    btn_dir = 4'b0000; clk_step();

    // Opposite direction
    btn_dir = 4'b0001; clk_step();
`ifdef DIR_REVERSE_BLOCK_EN
    check("reverse_count", queue_count, 0);
`else
    check("reverse_count", queue_count, 1);
`endif
    check("reverse_dropped", press_dropped, 0);
    btn_dir = 4'b0000; clk_step();
    btn_dir = 4'b0100; clk_step();
`ifdef DIR_REVERSE_BLOCK_EN
    check("prerst_count", queue_count, 1);
    check("prerst_full", queue_full, 0);
`else
    check("prerst_count", queue_count, 2);
    check("prerst_full", queue_full, 1);
`endif

    // Asynchronous reset mid-queue, between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_cur_dir", cur_dir, 4'b0010);
    check("arst_count", queue_count, 0);
    check("arst_full", queue_full, 0);
    check("arst_changed", dir_changed, 0);
    check("arst_dropped", press_dropped, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
